// File: rtl/da_bitplane_accumulator.sv
// -----------------------------------------------------------------------------
// da_bitplane_accumulator
//
// Bit-serial distributed-arithmetic inner product for one four-sample DCT
// butterfly group. Samples are captured once, then walked one bit plane per
// cycle (MSB first). Each plane addresses an external combinational
// coefficient ROM with offset-binary coding; the signed term is folded into a
// full-precision shift-and-add accumulator. After the last plane a single
// commit cycle copies the accumulator into the result register, which is then
// offered with a valid/ready handshake.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   i_in_valid   x0..x3 present
//   o_in_ready   block accepts a new sample group (IDLE only)
//   i_x0..i_x3   signed samples, SAMPLE_W bits each
//   o_rom_cs     coefficient ROM chip select (RUN only)
//   o_rom_addr   3-bit ROM address, zero outside RUN
//   i_rom_data   signed ROM word, valid in the same cycle as o_rom_addr
//   o_out_valid  o_z holds a finished result
//   i_out_ready  consumer takes o_z
//   o_z          signed result, ACC_W bits
// -----------------------------------------------------------------------------
module da_bitplane_accumulator #(
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned COEF_W   = 16,
    parameter int unsigned ACC_W    = SAMPLE_W + COEF_W + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_in_valid,
    output logic                o_in_ready,
    input  logic [SAMPLE_W-1:0] i_x0,
    input  logic [SAMPLE_W-1:0] i_x1,
    input  logic [SAMPLE_W-1:0] i_x2,
    input  logic [SAMPLE_W-1:0] i_x3,
    output logic                o_rom_cs,
    output logic [2:0]          o_rom_addr,
    input  logic [COEF_W-1:0]   i_rom_data,
    output logic                o_out_valid,
    input  logic                i_out_ready,
    output logic [ACC_W-1:0]    o_z
);

    localparam int unsigned     CNT_W   = (SAMPLE_W > 1) ? $clog2(SAMPLE_W) : 1;
    localparam logic [CNT_W-1:0] CNT_MSB = CNT_W'(SAMPLE_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [SAMPLE_W-1:0]     r_x0, r_x1, r_x2, r_x3;
    logic [CNT_W-1:0]        r_bit_cnt;
    logic signed [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0]        r_z;
    logic                    r_out_valid;

    logic                    w_accept;
    logic                    w_commit;
    logic                    w_release;
    logic                    w_b0, w_b1, w_b2, w_b3;
    logic [2:0]              w_addr;
    logic signed [ACC_W-1:0] w_coef;
    logic signed [ACC_W-1:0] w_term;
    logic signed [ACC_W-1:0] w_acc_next;

    // Sample registers shift left every plane, so the current plane is
    // always their MSB column.
    assign w_b0 = r_x0[SAMPLE_W-1];
    assign w_b1 = r_x1[SAMPLE_W-1];
    assign w_b2 = r_x2[SAMPLE_W-1];
    assign w_b3 = r_x3[SAMPLE_W-1];

    // Offset-binary folding: the ROM only stores the b0=0 half of the table,
    // the other half is its negation at the complemented address.
    assign w_addr = {w_b1, w_b2, w_b3} ^ {3{w_b0}};
    assign w_coef = ACC_W'($signed(i_rom_data));
    assign w_term = w_b0 ? -w_coef : w_coef;

    // The sign plane carries negative weight in two's complement.
    assign w_acc_next = (r_bit_cnt == CNT_MSB) ? -w_term : ((r_acc <<< 1) + w_term);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_in_ready   = 1'b0;
        o_rom_cs     = 1'b0;
        o_rom_addr   = 3'b000;
        w_accept     = 1'b0;
        w_commit     = 1'b0;
        w_release    = 1'b0;
        unique case (r_state)
            IDLE: begin
                o_in_ready = 1'b1;
                if (i_in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                o_rom_cs   = 1'b1;
                o_rom_addr = w_addr;
                if (r_bit_cnt == '0) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                // First DONE cycle commits the accumulator; the handshake is
                // only honoured once the result is actually on o_z.
                if (!r_out_valid) begin
                    w_commit = 1'b1;
                end else if (i_out_ready) begin
                    w_release    = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x0        <= '0;
            r_x1        <= '0;
            r_x2        <= '0;
            r_x3        <= '0;
            r_bit_cnt   <= '0;
            r_acc       <= '0;
            r_z         <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_x0      <= i_x0;
                r_x1      <= i_x1;
                r_x2      <= i_x2;
                r_x3      <= i_x3;
                r_bit_cnt <= CNT_MSB;
            end else if (r_state == RUN) begin
                r_x0  <= r_x0 << 1;
                r_x1  <= r_x1 << 1;
                r_x2  <= r_x2 << 1;
                r_x3  <= r_x3 << 1;
                r_acc <= w_acc_next;
                if (r_bit_cnt != '0) begin
                    r_bit_cnt <= r_bit_cnt - CNT_W'(1);
                end
            end

            if (w_commit) begin
                r_z         <= r_acc;
                r_out_valid <= 1'b1;
            end else if (w_release) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_z         = r_z;

endmodule

// File: tb/tb_da_bitplane_accumulator.sv
// -----------------------------------------------------------------------------
// tb_da_bitplane_accumulator
//
// Directed bench for da_bitplane_accumulator (SAMPLE_W=COEF_W=16). Two ROM
// stubs: constant 1, and identity (data = address). With the identity stub the
// offset-binary DA collapses to z = 4*x1 + 2*x2 + x3 - 7*x0 (signed), and with
// the constant stub to z = -1 - 2*x0; the expected values below follow that.
// -----------------------------------------------------------------------------
module tb_da_bitplane_accumulator;

    localparam int SW = 16;
    localparam int CW = 16;
    localparam int AW = SW + CW + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [SW-1:0] x0 = '0, x1 = '0, x2 = '0, x3 = '0;
    logic          rom_cs;
    logic [2:0]    rom_addr;
    logic [CW-1:0] rom_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [AW-1:0] z;

    bit rom_ident = 1'b0;

    int n_pass  = 0;
    int n_total = 0;

    logic [2:0] hist[$];

    da_bitplane_accumulator #(
        .SAMPLE_W (SW),
        .COEF_W   (CW),
        .ACC_W    (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_x0        (x0),
        .i_x1        (x1),
        .i_x2        (x2),
        .i_x3        (x3),
        .o_rom_cs    (rom_cs),
        .o_rom_addr  (rom_addr),
        .i_rom_data  (rom_data),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_z         (z)
    );

    always #5 clk = ~clk;

    always_comb rom_data = rom_ident ? CW'(rom_addr) : CW'(1);

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200us");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic signed [63:0] zs();
        logic signed [63:0] v;
        v = $signed(z);
        return v;
    endfunction

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    function automatic int count_ne(input logic [2:0] v, input int first, input int last);
        int n = 0;
        for (int i = first; i <= last; i++) begin
            if (i >= hist.size() || hist[i] !== v) n++;
        end
        return n;
    endfunction

    function automatic logic signed [63:0] ref_id(input logic [15:0] a, input logic [15:0] b,
                                                  input logic [15:0] c, input logic [15:0] d);
        logic signed [63:0] sa, sb, sc, sd;
        sa = $signed(a);
        sb = $signed(b);
        sc = $signed(c);
        sd = $signed(d);
        return 4 * sb + 2 * sc + sd - 7 * sa;
    endfunction

    // Present one group in IDLE, accept it, then scramble the inputs and wait
    // for out_valid, logging the ROM address of every RUN cycle.
    task automatic run_block(input string tag, input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] c, input logic [15:0] d,
                             output logic signed [63:0] zr, output int latency);
        hist.delete();
        check({tag, "_in_ready"}, in_ready, 1);
        x0 = a;
        x1 = b;
        x2 = c;
        x3 = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        x0 = ~a;
        x1 = ~b;
        x2 = ~c;
        x3 = ~d;
        latency = 0;
        while (!out_valid && latency < 40) begin
            if (rom_cs) hist.push_back(rom_addr);
            tick();
            latency++;
        end
        zr = zs();
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, out_valid, 0);
        check({tag, "_back_idle"}, in_ready, 1);
    endtask

    initial begin
        logic signed [63:0] zr;
        logic signed [63:0] zkeep;
        int lat;
        int seen;
        logic [15:0] vec[3][4];

        // Reset values while rst_n is held low.
        tick();
        tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_rom_cs", rom_cs, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_z", zs(), 0);
        rst_n = 1'b1;
        tick();

        // Constant ROM, all-zero samples: address 000 every plane, z = -1.
        rom_ident = 1'b0;
        run_block("c0", 16'h0000, 16'h0000, 16'h0000, 16'h0000, zr, lat);
        check("c0_z", zr, -1);
        check("c0_latency", lat, 17);
        check("c0_run_cycles", hist.size(), 16);
        check("c0_addr_000", count_ne(3'b000, 0, 15), 0);
        check("c0_done_rom_cs", rom_cs, 0);
        check("c0_done_rom_addr", rom_addr, 0);
        check("c0_done_in_ready", in_ready, 0);
        release_result("c0");

        // Constant ROM, x0 = 1: LSB plane folds to 111, z = -3.
        run_block("c1", 16'h0001, 16'h0000, 16'h0000, 16'h0000, zr, lat);
        check("c1_z", zr, -3);
        check("c1_addr_lsb", (hist.size() == 16) ? hist[15] : 3'bxxx, 3'b111);
        check("c1_addr_rest", count_ne(3'b000, 0, 14), 0);
        release_result("c1");

        // Identity ROM.
        rom_ident = 1'b1;
        run_block("i1", 16'h0000, 16'h0000, 16'h0000, 16'h0001, zr, lat);
        check("i1_z", zr, 1);
        release_result("i1");

        // Sign plane has weight -2^15: 0x8000 on x3 gives -32768.
        run_block("i2", 16'h0000, 16'h0000, 16'h0000, 16'h8000, zr, lat);
        check("i2_z", zr, -32768);
        release_result("i2");

        run_block("i3", 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, zr, lat);
        check("i3_z", zr, -4);
        check("i3_addr_100", count_ne(3'b100, 0, 15), 0);
        release_result("i3");

        // 4*(-292) + 2*3855 + (-32767) - 7*4660
        run_block("i4", 16'h1234, 16'hFEDC, 16'h0F0F, 16'h8001, zr, lat);
        check("i4_z", zr, -58845);
        check("i4_latency", lat, 17);
        release_result("i4");

        // 7*32767 - 7*(-32768): widest positive corner.
        run_block("i5", 16'h8000, 16'h7FFF, 16'h7FFF, 16'h7FFF, zr, lat);
        check("i5_z", zr, 458745);

        // Backpressure: hold the result for 5 cycles while in_valid toggles.
        zkeep = zs();
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            x0 = 16'($urandom);
            x1 = 16'($urandom);
            tick();
            check("bp_out_valid", out_valid, 1);
            check("bp_z_stable", zs(), zkeep);
            check("bp_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        release_result("bp");
        check("bp_z_hold_idle", zs(), zkeep);

        // Reset in the 8th RUN cycle discards the block.
        x0 = 16'h0101;
        x1 = 16'h0202;
        x2 = 16'h0303;
        x3 = 16'h0404;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("mr_z_hold_run", zs(), zkeep);
        repeat (7) tick();
        check("mr_in_run", rom_cs, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_rom_cs", rom_cs, 0);
        check("mr_rom_addr", rom_addr, 0);
        check("mr_out_valid", out_valid, 0);
        check("mr_z", zs(), 0);
        check("mr_in_ready", in_ready, 1);
        tick();
        tick();
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            tick();
            if (out_valid) seen++;
        end
        check("mr_no_result", seen, 0);
        // 2*3 - 7*(-1)
        run_block("mr", 16'hFFFF, 16'h0000, 16'h0003, 16'h0000, zr, lat);
        check("mr_next_z", zr, 13);
        release_result("mr");

        // Back-to-back with in_valid and out_ready held high.
        vec[0] = '{16'h0000, 16'h0001, 16'h0000, 16'h0000};
        vec[1] = '{16'h0002, 16'h0000, 16'hFFFE, 16'h0005};
        vec[2] = '{16'h7FFF, 16'h8000, 16'h0100, 16'hFFF0};
        begin
            int ai = 0;
            int ri = 0;
            int t = 0;
            int last_t = -1;
            bit acc_now;
            x0 = vec[0][0];
            x1 = vec[0][1];
            x2 = vec[0][2];
            x3 = vec[0][3];
            in_valid = 1'b1;
            out_ready = 1'b1;
            while (ri < 3 && t < 100) begin
                acc_now = in_ready && in_valid;
                if (out_valid) begin
                    check("b2b_z", zs(), ref_id(vec[ri][0], vec[ri][1], vec[ri][2], vec[ri][3]));
                    if (last_t >= 0) check("b2b_period", t - last_t, 19);
                    last_t = t;
                    ri++;
                end
                tick();
                t++;
                if (acc_now) begin
                    ai++;
                    if (ai < 3) begin
                        x0 = vec[ai][0];
                        x1 = vec[ai][1];
                        x2 = vec[ai][2];
                        x3 = vec[ai][3];
                    end else begin
                        in_valid = 1'b0;
                    end
                end
            end
            check("b2b_results", ri, 3);
            in_valid = 1'b0;
            out_ready = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
